// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_pkg                                                     |
// | Shared state encoding and sizing helper for the bit-serial adder.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fsm_ha_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ha_cell                                                              |
// | Half adder built from a 1:4 demux decode of its two input bits.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  logic [3:0] w_y;

  always_comb begin
    w_y = 4'b0001 << {x, y};
  end

  assign s = w_y[1] | w_y[2];
  assign c = w_y[3];

endmodule
`default_nettype wire

// File: rtl/serial_adder_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_fsm                                                     |
// | LSB-first bit-serial WIDTH-bit adder; SERIAL_ADDER_SUB_EN adds a     |
// | sub port selecting a-b.                                              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_init;
  logic             w_part;
  logic             w_c1;
  logic             w_c2;
  logic             w_bit;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtract: invert b and inject the +1 through the carry.
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_init = sub;
`else
  assign w_b_load     = b;
  assign w_carry_init = 1'b0;
`endif

  ha_cell u_ha0 (.x(r_a[0]), .y(r_b[0]),  .s(w_part), .c(w_c1));
  ha_cell u_ha1 (.x(w_part), .y(r_carry), .s(w_bit),  .c(w_c2));

  assign w_carry_next = w_c1 | w_c2;
  assign w_sum_next   = {w_bit, r_sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back adds.
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= w_b_load;
            r_carry  <= w_carry_init;
            r_cnt    <= '0;
            r_sum_sr <= '0;
            busy     <= 1'b1;
            r_state  <= SHIFT;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          r_sum_sr <= w_sum_next;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_carry  <= w_carry_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            sum     <= w_sum_next;
            cout    <= w_carry_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_adder_fsm                                                  |
// | Randomised self-checking bench against an arithmetic reference.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_serial_adder_fsm;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         sub   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cout, sum} from plain integer arithmetic.
  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint unsigned r;
    logic [W:0] res;
    if (s) begin
      r = (longint'(x) - longint'(y)) & ((64'd1 << W) - 1);
      res = {(x >= y), r[W-1:0]};
    end else begin
      r = longint'(x) + longint'(y);
      res = {(r >= (64'd1 << W)), r[W-1:0]};
    end
    return res;
  endfunction

  // One complete add; optionally pulses start with junk operands mid-shift.
  task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input int inject);
    logic [W:0] exp;
    int nb;
    int nd;
    exp = ref_result(x, y, s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = ~s;
    nb = 0;
    nd = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
      if (i == inject) begin
        a = W'($urandom); b = W'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("busy_cycles", nb, W);
    chk("early_done", nd, 0);
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("sum_held", sum, exp[W-1:0]);
  endtask

  task automatic run_b2b();
    int t;
    int t1;
    int t2;
    logic busy_after;
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h7F; b = 8'h01;
    t = 0; t1 = -1; t2 = -1; busy_after = 1'b0;
    while (t < 40 && t2 < 0) begin
      @(negedge clk);
      t++;
      if (t1 >= 0 && t == t1 + 1) busy_after = busy;
      if (done) begin
        if (t1 < 0) begin
          t1 = t;
          chk("b2b_sum1", sum, 8'h30);
          chk("b2b_cout1", cout, 1'b0);
        end else begin
          t2 = t;
          chk("b2b_sum2", sum, 8'h80);
          chk("b2b_cout2", cout, 1'b0);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", t1, W + 1);
    chk("b2b_second_seen", (t2 >= 0), 1'b1);
    chk("b2b_spacing", t2 - t1, W + 1);
    chk("b2b_no_idle", busy_after, 1'b1);
    @(negedge clk);
    chk("b2b_idle_done", done, 1'b0);
    chk("b2b_idle_busy", busy, 1'b0);
  endtask

  task automatic run_reset_mid();
    int nd;
    int nb;
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    nb = 0;
    repeat (2 * W + 2) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("post_rst_done", nd, 0);
    chk("post_rst_busy", nb, 0);
  endtask

  initial begin
    logic s;
    int inj;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sum", sum, '0);
    chk("reset_cout", cout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_add(8'h05, 8'h03, 1'b0, -1);
    run_add(8'hFF, 8'h01, 1'b0, -1);
    run_add(8'h22, 8'h44, 1'b0, 2);
    run_add(8'hFF, 8'hFF, 1'b0, -1);
    run_b2b();
    run_add(8'hA5, 8'h3C, 1'b0, -1);
    run_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    run_add(8'h05, 8'h07, 1'b1, -1);
    run_add(8'h07, 8'h05, 1'b1, -1);
    run_add(8'h00, 8'h00, 1'b1, -1);
`endif
    for (int k = 0; k < 16; k++) begin
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 3)) : -1;
      run_add(W'($urandom), W'($urandom), s, inj);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
